// File: rtl/bayes_scan_ctrl.sv
// Sequencer for the naive-Bayes datapath: clears it, streams every (class, attribute)
// probability from the ROM in lock-step with its indices, then collects the label.
module bayes_scan_ctrl #(
    parameter int N_CLASS    = 10,
    parameter int N_ATTR     = 784,
    parameter int PIX_TH     = 128,
    parameter int LV_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    output logic        busy,
    output logic [9:0]  img_addr,
    input  logic [7:0]  img_rdata,
    output logic [14:0] rom_addr,
    input  logic [9:0]  rom_rdata,
    output logic        dp_rstn,
    output logic [9:0]  dp_data_pxc,
    output logic [3:0]  dp_c_idx,
    output logic [9:0]  dp_attri_idx,
    input  logic        dp_label_valid,
    input  logic [3:0]  dp_label,
    output logic        result_valid,
    output logic [3:0]  result_label,
    output logic        result_err
);

    typedef enum logic [2:0] {IDLE, CLR, SCAN, BIAS, FINAL, WAIT} state_t;

    localparam logic [3:0] C_LAST  = 4'(N_CLASS - 1);
    localparam logic [3:0] C_FINAL = 4'(N_CLASS);
    localparam logic [9:0] A_LAST  = 10'(N_ATTR - 1);
    localparam logic [9:0] A_BIAS  = 10'(N_ATTR);
    localparam logic [7:0] TO_LAST = 8'(LV_TIMEOUT - 1);
    localparam logic [7:0] PIX     = 8'(PIX_TH);

    state_t      state;
    logic [3:0]  c;
    logic [9:0]  a;
    logic [7:0]  wait_cnt;

    logic        s1_scan;
    logic [3:0]  s1_c;
    logic [9:0]  s1_a;
    logic        s2_scan;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            c            <= '0;
            a            <= '0;
            wait_cnt     <= '0;
            busy         <= 1'b0;
            dp_rstn      <= 1'b0;
            result_valid <= 1'b0;
            result_label <= '0;
            result_err   <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    dp_rstn <= 1'b1;
                    if (start) begin
                        state   <= CLR;
                        busy    <= 1'b1;
                        dp_rstn <= 1'b0;
                    end
                end
                CLR: begin
                    dp_rstn <= 1'b1;
                    c       <= '0;
                    a       <= '0;
                    state   <= SCAN;
                end
                SCAN: begin
                    if (a == A_LAST) begin
                        state <= BIAS;
                    end else begin
                        a <= a + 10'd1;
                    end
                end
                BIAS: begin
                    if (c == C_LAST) begin
                        state <= FINAL;
                    end else begin
                        c     <= c + 4'd1;
                        a     <= '0;
                        state <= SCAN;
                    end
                end
                FINAL: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // The result pulse cycle stays in WAIT so a start there is ignored.
                    if (result_valid) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (dp_label_valid) begin
                        result_valid <= 1'b1;
                        result_label <= dp_label;
                        result_err   <= 1'b0;
                    end else if (wait_cnt == TO_LAST) begin
                        result_valid <= 1'b1;
                        result_label <= 4'hF;
                        result_err   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Token pipe: stage 1 lines up with the pixel, stage 2 with the ROM word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_scan      <= 1'b0;
            s1_c         <= '0;
            s1_a         <= '0;
            s2_scan      <= 1'b0;
            dp_c_idx     <= '0;
            dp_attri_idx <= '0;
        end else begin
            s1_scan <= (state == SCAN);
            case (state)
                SCAN: begin
                    s1_c <= c;
                    s1_a <= a;
                end
                BIAS: begin
                    s1_c <= c;
                    s1_a <= A_BIAS;
                end
                FINAL: begin
                    s1_c <= C_FINAL;
                    s1_a <= A_BIAS;
                end
                default: begin
                    s1_c <= '0;
                    s1_a <= '0;
                end
            endcase
            s2_scan      <= s1_scan;
            dp_c_idx     <= s1_c;
            dp_attri_idx <= s1_a;
        end
    end

    assign img_addr    = (state == SCAN) ? a : '0;
    assign rom_addr    = s1_scan ? {s1_c, s1_a, (img_rdata >= PIX)} : '0;
    assign dp_data_pxc = s2_scan ? rom_rdata : '0;

endmodule

// File: tb/tb_bayes_scan_ctrl.sv
// Self-checking bench for bayes_scan_ctrl with image/ROM memories and a datapath
// stub that accumulates per-class sums and reports the minimum-sum class.
module tb_bayes_scan_ctrl;

    localparam int NC     = 10;
    localparam int NA     = 784;
    localparam int TO     = 4;
    localparam int SLOTS  = NC * (NA + 1);
    localparam int R_NORM = SLOTS + 5;
    localparam int R_TO   = SLOTS + 2 + TO;

    logic        clk;
    logic        rstn;
    logic        start;
    logic        busy;
    logic [9:0]  img_addr;
    logic [7:0]  img_rdata;
    logic [14:0] rom_addr;
    logic [9:0]  rom_rdata;
    logic        dp_rstn;
    logic [9:0]  dp_data_pxc;
    logic [3:0]  dp_c_idx;
    logic [9:0]  dp_attri_idx;
    logic        dp_label_valid;
    logic [3:0]  dp_label;
    logic        result_valid;
    logic [3:0]  result_label;
    logic        result_err;

    bayes_scan_ctrl #(.N_CLASS(NC), .N_ATTR(NA), .PIX_TH(128), .LV_TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn), .start(start), .busy(busy),
        .img_addr(img_addr), .img_rdata(img_rdata),
        .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .dp_rstn(dp_rstn), .dp_data_pxc(dp_data_pxc), .dp_c_idx(dp_c_idx),
        .dp_attri_idx(dp_attri_idx), .dp_label_valid(dp_label_valid), .dp_label(dp_label),
        .result_valid(result_valid), .result_label(result_label), .result_err(result_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] img_mem [0:NA-1];
    logic [9:0] rom_mem [0:32767];
    int         rom_mode;
    bit         stub_dead;
    logic [14:0] cap_rom [0:15];

    typedef struct {
        logic [7:0] pix;
        logic       exp_bit;
    } thr_vec_t;
    thr_vec_t thr [0:5];

    function automatic logic [9:0] rom_fn(input int c, input int a, input logic b);
        logic [14:0] ix;
        ix = {4'(c), 10'(a), b};
        case (rom_mode)
            0:       return 10'(a);
            1:       return (c == 3) ? 10'd1 : 10'd5;
            default: return rom_mem[ix];
        endcase
    endfunction

    always @(posedge clk) begin
        img_rdata <= (img_addr < NA) ? img_mem[img_addr] : 8'h00;
        rom_rdata <= rom_fn(int'(rom_addr[14:11]), int'(rom_addr[10:1]), rom_addr[0]);
    end

    int         sums [0:NC-1];
    logic       stub_lv;
    logic [3:0] stub_label;

    function automatic logic [3:0] argmin_sums();
        int best;
        best = 0;
        for (int i = 1; i < NC; i++) if (sums[i] < sums[best]) best = i;
        return 4'(best);
    endfunction

    always @(posedge clk) begin
        if (!dp_rstn) begin
            for (int i = 0; i < NC; i++) sums[i] <= 0;
            stub_lv    <= 1'b0;
            stub_label <= 4'd0;
        end else begin
            stub_lv <= 1'b0;
            if (dp_c_idx == NC) begin
                if (!stub_dead) begin
                    stub_lv    <= 1'b1;
                    stub_label <= argmin_sums();
                end
            end else if (dp_c_idx < NC) begin
                sums[dp_c_idx] <= sums[dp_c_idx] + int'(dp_data_pxc);
            end
        end
    end

    assign dp_label_valid = stub_lv;
    assign dp_label       = stub_label;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference classification: sum of -log P over all attributes, smallest sum wins.
    function automatic int model_label();
        int best;
        longint bs, s;
        best = 0;
        bs   = 0;
        for (int c = 0; c < NC; c++) begin
            s = 0;
            for (int a = 0; a < NA; a++) s += longint'(rom_fn(c, a, img_mem[a] >= 8'd128));
            if (c == 0 || s < bs) begin
                bs   = s;
                best = c;
            end
        end
        return best;
    endfunction

    // Token k of the scan order: class-major, NA attributes then a bias slot, then final.
    task automatic tok(input int k, output int c, output int a, output int d, output bit scan);
        c    = k / (NA + 1);
        a    = k % (NA + 1);
        scan = 1'b0;
        d    = 0;
        if (c >= NC) begin
            c = NC;
            a = NA;
        end else if (a != NA) begin
            scan = 1'b1;
            d    = int'(rom_fn(c, a, img_mem[a] >= 8'd128));
        end
    endtask

    function automatic logic [55:0] pack_outs();
        return {busy, img_addr, rom_addr, dp_data_pxc, dp_c_idx, dp_attri_idx,
                result_valid, result_label, result_err};
    endfunction

    task automatic do_run(input string nm, input bit exp_to, input bit try_start);
        int n, r, dp_bad, addr_bad, busy_bad, rst_bad, exp_label, exp_r, c, a, d;
        bit seen, scan;
        logic clr0;
        logic [3:0] lab;
        logic err;
        exp_label = exp_to ? 15 : model_label();
        exp_r     = exp_to ? R_TO : R_NORM;
        dp_bad = 0; addr_bad = 0; busy_bad = 0; rst_bad = 0;
        seen = 1'b0; r = -1; lab = '0; err = 1'b0; clr0 = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (!seen && n <= SLOTS + 60) begin
            if (n > 0) @(negedge clk);
            if (n == 0) clr0 = dp_rstn;
            else if (dp_rstn !== 1'b1) rst_bad++;
            if (n >= 2 && n < 18) cap_rom[n-2] = rom_addr;
            if (n >= 3 && n - 3 <= SLOTS) begin
                tok(n - 3, c, a, d, scan);
                if ({dp_c_idx, dp_attri_idx, dp_data_pxc} !== {4'(c), 10'(a), 10'(d)}) dp_bad++;
            end else if ({dp_c_idx, dp_attri_idx, dp_data_pxc} !== 24'd0) dp_bad++;
            if (n >= 2 && n - 2 < SLOTS) begin
                tok(n - 2, c, a, d, scan);
                if (scan && rom_addr !== {4'(c), 10'(a), img_mem[a] >= 8'd128}) addr_bad++;
            end
            if (n >= 1 && n - 1 < SLOTS) begin
                tok(n - 1, c, a, d, scan);
                if (scan && img_addr !== 10'(a)) addr_bad++;
            end
            if (busy !== 1'b1) busy_bad++;
            if (result_valid === 1'b1) begin
                seen = 1'b1;
                r    = n;
                lab  = result_label;
                err  = result_err;
            end
            n++;
        end
        chk({nm, "_clr_cycle0"}, clr0, 0);
        chk({nm, "_dp_rstn_high"}, rst_bad, 0);
        chk({nm, "_result_seen"}, seen, 1);
        chk({nm, "_result_cycle"}, r, exp_r);
        chk({nm, "_label"}, lab, exp_label);
        chk({nm, "_err"}, err, exp_to);
        chk({nm, "_dp_seq"}, dp_bad, 0);
        chk({nm, "_addr_seq"}, addr_bad, 0);
        chk({nm, "_busy_seq"}, busy_bad, 0);
        if (try_start) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_after_busy_rv_rstn"}, {busy, result_valid, dp_rstn}, 3'b001);
        repeat (3) @(negedge clk);
        chk({nm, "_held"}, {busy, result_label, result_err}, {1'b0, lab, err});
    endtask

    initial begin
        int idle_bad;
        rstn = 1'b0;
        start = 1'b0;
        rom_mode = 0;
        stub_dead = 1'b0;
        for (int i = 0; i < NA; i++) img_mem[i] = 8'd0;
        for (int i = 0; i < 32768; i++) rom_mem[i] = 10'(i);
        thr[0] = '{8'd127, 1'b0};
        thr[1] = '{8'd128, 1'b1};
        thr[2] = '{8'd0,   1'b0};
        thr[3] = '{8'd255, 1'b1};
        thr[4] = '{8'd129, 1'b1};
        thr[5] = '{8'd126, 1'b0};

        #1;
        chk("reset_outs", pack_outs(), 0);
        chk("reset_dp_rstn", dp_rstn, 0);
        repeat (3) @(negedge clk);
        chk("reset_dp_rstn_clocked", dp_rstn, 0);
        rstn = 1'b1;
        #1;
        chk("dp_rstn_before_edge", dp_rstn, 0);
        idle_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (pack_outs() !== 56'd0 || dp_rstn !== 1'b1) idle_bad++;
        end
        chk("idle_20", idle_bad, 0);

        // All-dark image, ROM word = attribute index: every class ties, class 0 wins.
        do_run("mode0", 1'b0, 1'b1);

        rom_mode = 1;
        for (int i = 0; i < NA; i++) img_mem[i] = 8'd200;
        do_run("class3", 1'b0, 1'b0);

        rom_mode = 0;
        stub_dead = 1'b1;
        for (int i = 0; i < NA; i++) img_mem[i] = 8'd0;
        for (int i = 0; i < 6; i++) img_mem[i] = thr[i].pix;
        do_run("timeout", 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("thr_bit_a%0d", i), cap_rom[i][0], thr[i].exp_bit);
            chk($sformatf("thr_idx_a%0d", i), cap_rom[i][14:1], 14'(i));
        end
        stub_dead = 1'b0;

        rom_mode = 2;
        for (int i = 0; i < 32768; i++) rom_mem[i] = 10'($urandom_range(0, 1023));
        for (int i = 0; i < NA; i++) img_mem[i] = 8'($urandom_range(0, 255));
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (1 + 4 * (NA + 1) + 100) @(negedge clk);
        chk("abort_pos", {busy, img_addr}, {1'b1, 10'd100});
        #2 rstn = 1'b0;
        #1;
        chk("abort_outs", {pack_outs(), dp_rstn}, 57'd0);
        idle_bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (result_valid !== 1'b0 || dp_rstn !== 1'b0) idle_bad++;
        end
        rstn = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (pack_outs() !== 56'd0 || dp_rstn !== 1'b1) idle_bad++;
        end
        chk("abort_quiet", idle_bad, 0);
        do_run("abort_rerun", 1'b0, 1'b0);

        for (int i = 0; i < 32768; i++) rom_mem[i] = 10'($urandom_range(0, 1023));
        for (int i = 0; i < NA; i++) img_mem[i] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(100, 160));
        do_run("random2", 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
